iir_coef_axil_slave: RTL and testbench
======================================

// Module: iir_coef_axil_slave
// PURPOSE
// AXI4-Lite responder (slave) holding the four coefficient words of the parallel 4-tap IIR.
// It accepts single-beat writes and reads from an AXI4-Lite initiator, such as the PS or the bench VIP master.
// It drives the coefficients to the filter datapath and pulses coef_update on every committed write.
// It sits behind S00_AXI in the IP wrapper.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32  data bus width; fixed at 32, byte strobes = 4
// C_S_AXI_ADDR_WIDTH  5   byte address width; word index = addr[4:2], indices 0..3 valid, 4..7 unmapped
// COEF_RESET_VAL      0   reset value of every coefficient register
// PORTS
// S_AXI_ACLK     in   1   single clock, all logic rising-edge
// S_AXI_ARESETN  in   1   reset, synchronous, active-low
// S_AXI_AWADDR   in   5   write address;  S_AXI_AWPROT in 3 (ignored)
// S_AXI_AWVALID  in   1 / S_AXI_AWREADY out 1   write-address handshake
// S_AXI_WDATA    in   32  write data;  S_AXI_WSTRB in 4 byte enables
// S_AXI_WVALID   in   1 / S_AXI_WREADY  out 1   write-data handshake
// S_AXI_BRESP    out  2   00 OKAY, 10 SLVERR
// S_AXI_BVALID   out  1 / S_AXI_BREADY  in  1   write-response handshake
// S_AXI_ARADDR   in   5   read address;  S_AXI_ARPROT in 3 (ignored)
// S_AXI_ARVALID  in   1 / S_AXI_ARREADY out 1   read-address handshake
// S_AXI_RDATA    out  32  read data;  S_AXI_RRESP out 2 (00/10)
// S_AXI_RVALID   out  1 / S_AXI_RREADY  in  1   read-data handshake
// coef0..coef3   out  32  each, current coefficient registers
// coef_update    out  1   one-cycle pulse, one cycle after a register write commits
// BEHAVIOUR
// - Reset: synchronous, applies while ARESETN=0 at a clock edge.
//   - All READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, coef_update 0, coef0..3 = COEF_RESET_VAL.
//   - Holding buffers cleared. Reset mid-transaction discards it; no response is issued afterwards.
// - Write path: AW and W are captured independently into one-entry holding buffers.
//   - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID. AW and W may arrive in either order.
//   - AW and W may arrive in the same cycle, or up to any number of cycles apart.
//   - Commit cycle = first cycle with both held. In it: decode index, apply WSTRB per byte, set BVALID, clear both buffers.
//   - BRESP = 00 for index 0..3; BRESP = 10 for index 4..7, no register changes and no coef_update.
//   - BVALID holds until BVALID&&BREADY. Min latency: AW+W handshake in cycle N gives BVALID in N+1.
//   - No new AW/W is accepted while BVALID=1, so at most one write is outstanding.
//   - WSTRB=0000 on a valid index: BRESP OKAY, register unchanged, coef_update still pulses.
// - coef_update = 1 for exactly the cycle after a valid-index commit. Registers are already updated in that cycle.
// - Read path: ARREADY = !RVALID.
//   - On AR handshake: RDATA = register[index] (0 if unmapped), RRESP = 00 or 10, RVALID=1 next cycle.
//   - RDATA/RRESP stay stable until RVALID&&RREADY. Back-to-back reads give one read per 2 cycles minimum.
//   - Read and write channels are fully independent.
//   - Same-cycle read and write commit to one register: the read returns the pre-write value.
//     Coefficient update is atomic per AXI beat.
// - Address bits [1:0] are ignored; the access is word-aligned.
// - coefN drives registers directly, combinational from flops, no extra latency.
// TESTING
// - Reset, then write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back. Required:
//   - Each BRESP=00 and RDATA equals the written word.
//   - coef0..3 = 1..4.
//   - 4 coef_update pulses.
// - W before AW: WVALID at cycle 0, AWVALID at cycle 3, addr 0x8, data 0xDEADBEEF.
//   Required: BVALID at cycle 4, coef2=0xDEADBEEF, WREADY low cycles 1..4.
// - Strobes: coef1=0x11223344, then write 0xAABBCCDD with WSTRB=0101.
//   Required: coef1=0x11BB33DD, and a readback returning the same value.
// - Unmapped: write 0x14 and read 0x1C. Required: BRESP=10 and RRESP=10, RDATA=0.
//   coef0..3 unchanged, no coef_update.
// - Backpressure: hold BREADY=0 for 10 cycles after a write and issue a second AW/W pair.
//   Required: BVALID stays 1, AWREADY/WREADY stay 0, the second write commits only after B accepted.
//   Same with RREADY=0: RDATA stable.
// - Reset mid-write: assert ARESETN=0 after the AW handshake and before W.
//   Required: all registers = COEF_RESET_VAL, no BVALID afterwards.
//   A subsequent fresh write completes normally.

Source files
------------

// File: rtl/iir_coef_axil_slave.sv
// iir_coef_axil_slave: AXI4-Lite slave holding the four 4-tap IIR coefficient words
// Writes commit when both AW and W are held (or arriving); coef_update pulses in the cycle after a mapped commit.
module iir_coef_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [C_S_AXI_DATA_WIDTH-1:0] COEF_RESET_VAL = '0
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   coef0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   coef1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   coef2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   coef3,
   output logic                            coef_update
);
   localparam int NB = C_S_AXI_DATA_WIDTH / 8;
   logic [C_S_AXI_DATA_WIDTH-1:0] coef_r [4];
   logic                          ready_en;
   logic                          aw_held, w_held;
   logic [2:0]                    aw_idx, wr_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data, wr_data;
   logic [NB-1:0]                 w_strb, wr_strb;
   logic                          aw_hs, w_hs, ar_hs, commit;
   logic [2:0]                    ar_idx;
   logic                          unused;
   // ready_en keeps every READY low while in reset and for the first cycle after
   assign S_AXI_AWREADY = ready_en && !aw_held && !S_AXI_BVALID;
   assign S_AXI_WREADY  = ready_en && !w_held && !S_AXI_BVALID;
   assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;
   assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
   assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[4:2];
   assign wr_data = w_held ? w_data : S_AXI_WDATA;
   assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
   assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !S_AXI_BVALID;
   assign ar_idx  = S_AXI_ARADDR[4:2];
   assign coef0 = coef_r[0];
   assign coef1 = coef_r[1];
   assign coef2 = coef_r[2];
   assign coef3 = coef_r[3];
   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         ready_en     <= 1'b0;
         aw_held      <= 1'b0;
         aw_idx       <= '0;
         w_held       <= 1'b0;
         w_data       <= '0;
         w_strb       <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= 2'b00;
         coef_update  <= 1'b0;
         for (int i = 0; i < 4; i++) coef_r[i] <= COEF_RESET_VAL;
      end else begin
         ready_en <= 1'b1;
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[4:2];
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_idx[2] ? 2'b10 : 2'b00;
         end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
         coef_update <= commit && !wr_idx[2];
         if (commit && !wr_idx[2])
            for (int b = 0; b < NB; b++)
               if (wr_strb[b]) coef_r[wr_idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end
   // Read samples the registers before any same-edge write lands
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= 2'b00;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= ar_idx[2] ? '0 : coef_r[ar_idx[1:0]];
         S_AXI_RRESP  <= ar_idx[2] ? 2'b10 : 2'b00;
      end else if (S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end
endmodule

// File: tb/tb_iir_coef_axil_slave.sv
// tb_iir_coef_axil_slave: scenario tasks with response/read-data scoreboard queues
module tb_iir_coef_axil_slave;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        aresetn = 1'b0;
   logic [4:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic        bready = 1'b1, rready = 1'b1;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, arready, bvalid, rvalid, coef_update;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, coef0, coef1, coef2, coef3;
   logic [31:0] coefs [4];
   int checks = 0, errors = 0, upd_cnt = 0;
   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];
   assign coefs[0] = coef0;
   assign coefs[1] = coef1;
   assign coefs[2] = coef2;
   assign coefs[3] = coef3;
   iir_coef_axil_slave dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .coef0(coef0), .coef1(coef1), .coef2(coef2), .coef3(coef3), .coef_update(coef_update)
   );
   always @(posedge clk) if (coef_update === 1'b1) upd_cnt++;
   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
      int n = 0;
      logic ah, wh;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while ((awvalid || wvalid) && n < 100) begin
         ah = awready; wh = wready;
         @(negedge clk);
         if (ah) awvalid = 1'b0;
         if (wh) wvalid = 1'b0;
         n++;
      end
      while (bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      r = bresp;
      if (n >= 100) begin errors++; $display("FAIL write_timeout addr=%h", a); awvalid = 0; wvalid = 0; end
      @(negedge clk);
   endtask
   task automatic do_read(input logic [4:0] a, output logic [33:0] v);
      int n = 0;
      logic ah;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (arvalid && n < 100) begin
         ah = arready;
         @(negedge clk);
         if (ah) arvalid = 1'b0;
         n++;
      end
      while (rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      v = {rresp, rdata};
      if (n >= 100) begin errors++; $display("FAIL read_timeout addr=%h", a); arvalid = 0; end
      @(negedge clk);
   endtask
   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, coef_update, bresp, rresp, rdata} !== '0) begin
         errors++; $display("FAIL reset_outputs got=%b/%h required=0", {awready, wready, arready, bvalid, rvalid, coef_update, bresp, rresp}, rdata);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (coefs[i] !== 32'h0) begin errors++; $display("FAIL reset_coef%0d got=%h required=0", i, coefs[i]); end
      end
      aresetn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL ready_after_reset got=%b required=111", {awready, wready, arready}); end
   endtask
   task automatic test_basic();
      logic [1:0] r, e;
      logic [33:0] v, ev;
      int u0 = upd_cnt;
      for (int i = 0; i < 4; i++) begin
         exp_b.push_back(2'b00);
         do_write(5'(4 * i), 32'(i + 1), 4'hF, r);
         e = exp_b.pop_front();
         checks++;
         if (r !== e) begin errors++; $display("FAIL basic_bresp%0d got=%b required=%b", i, r, e); end
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (coefs[i] !== 32'(i + 1)) begin errors++; $display("FAIL basic_coef%0d got=%h required=%h", i, coefs[i], i + 1); end
      end
      checks++;
      if (upd_cnt - u0 != 4) begin errors++; $display("FAIL basic_updates got=%0d required=4", upd_cnt - u0); end
      for (int i = 0; i < 4; i++) begin
         exp_r.push_back({2'b00, 32'(i + 1)});
         do_read(5'(4 * i + (i & 1)), v);
         ev = exp_r.pop_front();
         checks++;
         if (v !== ev) begin errors++; $display("FAIL basic_read%0d got=%h required=%h", i, v, ev); end
      end
   endtask
   task automatic test_w_before_aw();
      logic [1:0] e;
      @(negedge clk);
      bready = 1'b0; awaddr = 5'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      exp_b.push_back(2'b00);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) wvalid = 1'b0;
         if (k == 4) awvalid = 1'b0;
         checks++;
         if (wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready_c%0d got=%b required=0", k, wready); end
         checks++;
         if (bvalid !== (k == 4)) begin errors++; $display("FAIL wfirst_bvalid_c%0d got=%b required=%b", k, bvalid, k == 4); end
         if (k == 3) awvalid = 1'b1;
      end
      e = exp_b.pop_front();
      checks++;
      if (bresp !== e) begin errors++; $display("FAIL wfirst_bresp got=%b required=%b", bresp, e); end
      checks++;
      if (coef2 !== 32'hDEADBEEF) begin errors++; $display("FAIL wfirst_coef2 got=%h required=deadbeef", coef2); end
      bready = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_strobes();
      logic [1:0] r, e;
      logic [33:0] v, ev;
      exp_b.push_back(2'b00);
      exp_b.push_back(2'b00);
      do_write(5'h04, 32'h11223344, 4'hF, r);
      e = exp_b.pop_front();
      checks++;
      if (r !== e) begin errors++; $display("FAIL strobe_bresp0 got=%b required=%b", r, e); end
      do_write(5'h04, 32'hAABBCCDD, 4'b0101, r);
      e = exp_b.pop_front();
      checks++;
      if (r !== e) begin errors++; $display("FAIL strobe_bresp1 got=%b required=%b", r, e); end
      checks++;
      if (coef1 !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_coef1 got=%h required=11bb33dd", coef1); end
      exp_r.push_back({2'b00, 32'h11BB33DD});
      do_read(5'h04, v);
      ev = exp_r.pop_front();
      checks++;
      if (v !== ev) begin errors++; $display("FAIL strobe_read got=%h required=%h", v, ev); end
   endtask
   task automatic test_unmapped();
      logic [1:0] r, e;
      logic [33:0] v, ev;
      logic [31:0] snap [4];
      int u0;
      for (int i = 0; i < 4; i++) snap[i] = coefs[i];
      repeat (2) @(negedge clk);
      u0 = upd_cnt;
      exp_b.push_back(2'b10);
      do_write(5'h14, 32'hCAFEF00D, 4'hF, r);
      e = exp_b.pop_front();
      checks++;
      if (r !== e) begin errors++; $display("FAIL unmapped_bresp got=%b required=%b", r, e); end
      exp_r.push_back({2'b10, 32'h0});
      do_read(5'h1C, v);
      ev = exp_r.pop_front();
      checks++;
      if (v !== ev) begin errors++; $display("FAIL unmapped_read got=%h required=%h", v, ev); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (coefs[i] !== snap[i]) begin errors++; $display("FAIL unmapped_coef%0d got=%h required=%h", i, coefs[i], snap[i]); end
      end
      checks++;
      if (upd_cnt != u0) begin errors++; $display("FAIL unmapped_update got=%0d required=%0d", upd_cnt, u0); end
   endtask
   task automatic test_backpressure();
      int n = 0;
      logic [1:0] e;
      logic [33:0] v0;
      @(negedge clk);
      bready = 1'b0; awaddr = 5'h00; wdata = 32'h0000AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      exp_b.push_back(2'b00);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      wdata = 32'h0000BBBB; awvalid = 1'b1; wvalid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if ({bvalid, awready, wready} !== 3'b100 || coef0 !== 32'h0000AAAA) begin
            errors++; $display("FAIL bp_hold_c%0d got=%b/%h required=100/0000aaaa", k, {bvalid, awready, wready}, coef0);
         end
         @(negedge clk);
      end
      e = exp_b.pop_front();
      checks++;
      if (bresp !== e) begin errors++; $display("FAIL bp_bresp got=%b required=%b", bresp, e); end
      exp_b.push_back(2'b00);
      bready = 1'b1;
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || coef0 !== 32'h0000AAAA) begin errors++; $display("FAIL bp_release got=%b/%h required=0/0000aaaa", bvalid, coef0); end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      e = exp_b.pop_front();
      checks++;
      if (bvalid !== 1'b1 || bresp !== e || coef0 !== 32'h0000BBBB) begin
         errors++; $display("FAIL bp_second got=%b/%b/%h required=1/%b/0000bbbb", bvalid, bresp, coef0, e);
      end
      @(negedge clk);
      rready = 1'b0; araddr = 5'h00; arvalid = 1'b1;
      exp_r.push_back({2'b00, 32'h0000BBBB});
      @(negedge clk);
      arvalid = 1'b0;
      v0 = exp_r.pop_front();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (rvalid !== 1'b1 || arready !== 1'b0 || {rresp, rdata} !== v0) begin
            errors++; $display("FAIL rbp_hold_c%0d got=%b/%b/%h required=1/0/%h", k, rvalid, arready, {rresp, rdata}, v0);
         end
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL rbp_release got=%b required=0", rvalid); end
   endtask
   task automatic test_reset_mid_write();
      logic [1:0] r, e;
      @(negedge clk);
      awaddr = 5'h04; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; aresetn = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (coefs[i] !== 32'h0) begin errors++; $display("FAIL midrst_coef%0d got=%h required=0", i, coefs[i]); end
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (bvalid !== 1'b0) begin errors++; $display("FAIL midrst_bvalid_c%0d got=%b required=0", k, bvalid); end
      end
      exp_b.push_back(2'b00);
      do_write(5'h0C, 32'h00000055, 4'hF, r);
      e = exp_b.pop_front();
      checks++;
      if (r !== e || coef3 !== 32'h55 || coef1 !== 32'h0) begin
         errors++; $display("FAIL midrst_fresh got=%b/%h/%h required=%b/00000055/0", r, coef3, coef1, e);
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_w_before_aw();
      test_strobes();
      test_unmapped();
      test_backpressure();
      test_reset_mid_write();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
